sig_ext: RTL and testbench

Immediate sign-extension unit for the datapath's decode stage. It widens a 16-bit instruction immediate to 32 bits on a purely combinational path, `out`, which feeds the ALU operand mux. It also produces zero-extended, upper-immediate (LUI) and branch-offset forms. All four forms are available combinationally and as a registered copy for the pipeline register.

---
 rtl/sig_ext.sv | 47 ++++
 tb/tb_sig_ext.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sig_ext.sv
// rtl/sig_ext.sv - immediate sign/zero/upper/branch extension with registered copies
module sig_ext #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH_IN-1:0]  in,
    output logic [WIDTH_OUT-1:0] out,
    output logic [WIDTH_OUT-1:0] out_zero,
    output logic [WIDTH_OUT-1:0] out_lui,
    output logic [WIDTH_OUT-1:0] out_br,
    output logic                 neg,
    output logic [WIDTH_OUT-1:0] out_q,
    output logic [WIDTH_OUT-1:0] out_zero_q,
    output logic [WIDTH_OUT-1:0] out_lui_q,
    output logic [WIDTH_OUT-1:0] out_br_q,
    output logic                 neg_q
);

    localparam int EXT = WIDTH_OUT - WIDTH_IN;

    // Pure wiring: replication and concatenation only, so X/Z on in passes straight through.
    assign neg      = in[WIDTH_IN-1];
    assign out      = {{EXT{in[WIDTH_IN-1]}}, in};
    assign out_zero = {{EXT{1'b0}}, in};
    assign out_lui  = {in, {EXT{1'b0}}};
    assign out_br   = {out[WIDTH_OUT-3:0], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            out_zero_q <= '0;
            out_lui_q  <= '0;
            out_br_q   <= '0;
            neg_q      <= 1'b0;
        end else if (en) begin
            out_q      <= out;
            out_zero_q <= out_zero;
            out_lui_q  <= out_lui;
            out_br_q   <= out_br;
            neg_q      <= neg;
        end
    end

endmodule

// File: tb/tb_sig_ext.sv
// tb/tb_sig_ext.sv - directed self-checking bench for sig_ext
module tb_sig_ext;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] in;
    logic [31:0] out, out_zero, out_lui, out_br;
    logic [31:0] out_q, out_zero_q, out_lui_q, out_br_q;
    logic        neg, neg_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sig_ext #(.WIDTH_IN(16), .WIDTH_OUT(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .in         (in),
        .out        (out),
        .out_zero   (out_zero),
        .out_lui    (out_lui),
        .out_br     (out_br),
        .neg        (neg),
        .out_q      (out_q),
        .out_zero_q (out_zero_q),
        .out_lui_q  (out_lui_q),
        .out_br_q   (out_br_q),
        .neg_q      (neg_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [31:0] o, input logic [31:0] z,
                         input logic [31:0] l, input logic [31:0] b, input logic n);
        chk({tag, " out_q"},      out_q,      o);
        chk({tag, " out_zero_q"}, out_zero_q, z);
        chk({tag, " out_lui_q"},  out_lui_q,  l);
        chk({tag, " out_br_q"},   out_br_q,   b);
        chk({tag, " neg_q"},      {31'b0, neg_q}, {31'b0, n});
    endtask

    task automatic apply(input logic [15:0] v);
        in = v;
        #100;
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        in    = 16'h0000;

        // Combinational path
        apply(16'd122);   chk("pos122 out", out, 32'h0000007A);   chk("pos122 neg", {31'b0, neg}, 32'h0);
        apply(16'd650);   chk("pos650 out", out, 32'h0000028A);   chk("pos650 neg", {31'b0, neg}, 32'h0);
        apply(16'd300);   chk("pos300 out", out, 32'h0000012C);   chk("pos300 neg", {31'b0, neg}, 32'h0);
        apply(16'd15000); chk("pos15000 out", out, 32'h00003A98); chk("pos15000 neg", {31'b0, neg}, 32'h0);

        apply(16'hC568);  chk("negC568 out", out, 32'hFFFFC568);  chk("negC568 neg", {31'b0, neg}, 32'h1);
        apply(16'hFF6A);
        chk("negFF6A out",      out,      32'hFFFFFF6A);
        chk("negFF6A out_zero", out_zero, 32'h0000FF6A);
        chk("negFF6A out_lui",  out_lui,  32'hFF6A0000);
        chk("negFF6A out_br",   out_br,   32'hFFFFFDA8);

        apply(16'h7FFF);
        chk("b7FFF out", out, 32'h00007FFF);
        chk("b7FFF out_br", out_br, 32'h0001FFFC);
        apply(16'h8000);
        chk("b8000 out", out, 32'hFFFF8000);
        chk("b8000 out_br", out_br, 32'hFFFE0000);
        chk("b8000 out_lui", out_lui, 32'h80000000);
        apply(16'h0000);
        chk("b0000 out", out, 32'h0);
        chk("b0000 out_zero", out_zero, 32'h0);
        chk("b0000 out_lui", out_lui, 32'h0);
        chk("b0000 out_br", out_br, 32'h0);
        chk("b0000 neg", {31'b0, neg}, 32'h0);
        apply(16'hFFFF);
        chk("bFFFF out", out, 32'hFFFFFFFF);
        chk("bFFFF out_zero", out_zero, 32'h0000FFFF);

        // Register path: reset for two cycles
        @(posedge clk); #1;
        reset = 1'b1;
        en    = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_q("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset comb out", out, 32'hFFFFFFFF);

        // Load 0xC568
        reset = 1'b0;
        en    = 1'b1;
        in    = 16'hC568;
        @(posedge clk); #1;
        chk_q("loadC568", 32'hFFFFC568, 32'h0000C568, 32'hC5680000, 32'hFFFF15A0, 1'b1);

        // Hold with en low while in changes
        en = 1'b0;
        in = 16'h0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_q("hold", 32'hFFFFC568, 32'h0000C568, 32'hC5680000, 32'hFFFF15A0, 1'b1);
        chk("hold comb out", out, 32'h00000001);

        // Load a positive value, then reset with en high: reset wins
        en = 1'b1;
        in = 16'h1234;
        @(posedge clk); #1;
        chk_q("load1234", 32'h00001234, 32'h00001234, 32'h12340000, 32'h000048D0, 1'b0);
        reset = 1'b1;
        chk("prio before out", out, 32'h00001234);
        @(posedge clk); #1;
        chk_q("prio", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("prio after out", out, 32'h00001234);

        // Stays cleared after reset drops until en is asserted
        reset = 1'b0;
        en    = 1'b0;
        @(posedge clk); #1;
        chk_q("postreset idle", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        en = 1'b1;
        in = 16'h8000;
        @(posedge clk); #1;
        chk_q("load8000", 32'hFFFF8000, 32'h00008000, 32'h80000000, 32'hFFFE0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
